wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between the WB pipeline stage and a 2-deep MDU result queue
// The pipeline has priority; queued MDU results drain in order, with a stall request when they starve.
module wb_port_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reg_writeW,
  input  logic        i_mem_to_regW,
  input  logic [31:0] i_alu_outW,
  input  logic [31:0] i_dm_outW,
  input  logic [4:0]  i_write_regW,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_reg,
  input  logic [31:0] i_mdu_data,
  output logic        o_mdu_ready,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_addr,
  output logic [31:0] o_rf_wdata,
  output logic        o_rf_src,
  output logic [1:0]  o_q_count,
  output logic [31:0] o_q_regs,
  output logic        o_stall_req
);

  logic [4:0]  qReg  [2];
  logic [31:0] qData [2];
  logic        rdPtr;
  logic        wrPtr;
  logic [1:0]  qCount;
  logic [1:0]  starveCnt;

  logic        pipeReq;
  logic [31:0] pipeData;
  logic        grantQ;
  logic        push;
  logic [4:0]  headReg;
  logic [4:0]  tailReg;

  assign pipeReq     = i_reg_writeW && (i_write_regW != 5'd0);
  assign pipeData    = i_mem_to_regW ? i_dm_outW : i_alu_outW;
  // Grant looks only at registered occupancy, so a same-cycle push is never bypassed.
  assign grantQ      = !pipeReq && (qCount != 2'd0);
  assign o_mdu_ready = (qCount != 2'd2);
  assign push        = i_mdu_valid && o_mdu_ready;
  assign headReg     = qReg[rdPtr];
  assign tailReg     = qReg[~rdPtr];
  assign o_q_count   = qCount;
  assign o_stall_req = (starveCnt == 2'd3);

  always_comb begin
    o_q_regs = 32'd0;
    if (qCount != 2'd0 && headReg != 5'd0) o_q_regs[headReg] = 1'b1;
    if (qCount == 2'd2 && tailReg != 5'd0) o_q_regs[tailReg] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdPtr      <= 1'b0;
      wrPtr      <= 1'b0;
      qCount     <= 2'd0;
      starveCnt  <= 2'd0;
      o_rf_we    <= 1'b0;
      o_rf_addr  <= 5'd0;
      o_rf_wdata <= 32'd0;
      o_rf_src   <= 1'b0;
    end else begin
      if (push) begin
        qReg[wrPtr]  <= i_mdu_reg;
        qData[wrPtr] <= i_mdu_data;
        wrPtr        <= ~wrPtr;
      end
      if (grantQ) rdPtr <= ~rdPtr;
      qCount <= qCount + {1'b0, push} - {1'b0, grantQ};

      if (grantQ || qCount == 2'd0) starveCnt <= 2'd0;
      else if (starveCnt != 2'd3)   starveCnt <= starveCnt + 2'd1;

      if (pipeReq) begin
        o_rf_we    <= 1'b1;
        o_rf_addr  <= i_write_regW;
        o_rf_wdata <= pipeData;
        o_rf_src   <= 1'b0;
      end else if (grantQ) begin
        // A queued result for r0 still consumes its slot but never writes.
        o_rf_we    <= (headReg != 5'd0);
        o_rf_addr  <= headReg;
        o_rf_wdata <= qData[rdPtr];
        o_rf_src   <= 1'b1;
      end else begin
        o_rf_we    <= 1'b0;
        o_rf_src   <= 1'b0;
      end
    end
  end

endmodule
